// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the Bitcoin miner block design:
//   ROUNDS        rounds per SHA-256 compression
//   K             SHA-256 round constants
//   SHA256_IV     SHA-256 initial hash value, H0 in [255:224]
//   miner_state_t search FSM states
//   ch/maj/big_sigma0/big_sigma1/small_sigma0/small_sigma1 round functions
//   byte_swap32 / byte_reverse256 endianness helpers
// ---------------------------------------------------------------------------
package miner_pkg;

   localparam int ROUNDS = 64;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] SHA256_IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   typedef enum logic [2:0] {
      IDLE,
      C1_LOAD,
      C1_RND,
      C1_FIN,
      C2_RND,
      C2_FIN
   } miner_state_t;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] byte_swap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // Reverses all 32 bytes: digest byte 0 lands in the least significant byte,
   // which turns a SHA-256 digest into Bitcoin's big-number display order.
   function automatic logic [255:0] byte_reverse256(input logic [255:0] x);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[8*i +: 8] = x[255-8*i -: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/sha256_round_core.sv
// ---------------------------------------------------------------------------
// sha256_round_core
// Iterative SHA-256 compression, one round per clock.
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture init_state/block and start a 64-round compression
//   init_state   chaining value, H0 in [255:224]
//   block        512-bit message block, W0 in [511:480]
//   digest       init_state + working variables (valid once rounds finish,
//                held until the next load)
//   rdy          high during the final round cycle; digest is valid from
//                the following cycle
// ---------------------------------------------------------------------------
module sha256_round_core
   import miner_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [255:0] init_state,
   input  logic [511:0] block,
   output logic [255:0] digest,
   output logic         rdy
);

   logic [31:0] v_reg     [0:7];   // a..h
   logic [31:0] hinit_reg [0:7];   // chaining value added back at the end
   logic [31:0] w_reg     [0:15];  // w_reg[0] is W[t]
   logic [5:0]  rnd_reg;
   logic        run_reg;

   logic [31:0] init_w [0:7];
   logic [31:0] blk_w  [0:15];
   logic [31:0] t1, t2, w_new;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_state_words
         assign init_w[gi] = init_state[255-32*gi -: 32];
         assign digest[255-32*gi -: 32] = hinit_reg[gi] + v_reg[gi];
      end
      for (gi = 0; gi < 16; gi++) begin : g_block_words
         assign blk_w[gi] = block[511-32*gi -: 32];
      end
   endgenerate

   always_comb begin
      t1 = v_reg[7] + big_sigma1(v_reg[4]) + ch(v_reg[4], v_reg[5], v_reg[6])
         + K[rnd_reg] + w_reg[0];
      t2 = big_sigma0(v_reg[0]) + maj(v_reg[0], v_reg[1], v_reg[2]);
      // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
      w_new = small_sigma1(w_reg[14]) + w_reg[9] + small_sigma0(w_reg[1]) + w_reg[0];
   end

   assign rdy = run_reg && (rnd_reg == 6'(ROUNDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            v_reg[i]     <= '0;
            hinit_reg[i] <= '0;
         end
         for (int i = 0; i < 16; i++) begin
            w_reg[i] <= '0;
         end
         rnd_reg <= '0;
         run_reg <= 1'b0;
      end else if (load) begin
         for (int i = 0; i < 8; i++) begin
            v_reg[i]     <= init_w[i];
            hinit_reg[i] <= init_w[i];
         end
         for (int i = 0; i < 16; i++) begin
            w_reg[i] <= blk_w[i];
         end
         rnd_reg <= '0;
         run_reg <= 1'b1;
      end else if (run_reg) begin
         v_reg[0] <= t1 + t2;
         v_reg[1] <= v_reg[0];
         v_reg[2] <= v_reg[1];
         v_reg[3] <= v_reg[2];
         v_reg[4] <= v_reg[3] + t1;
         v_reg[5] <= v_reg[4];
         v_reg[6] <= v_reg[5];
         v_reg[7] <= v_reg[6];
         for (int i = 0; i < 15; i++) begin
            w_reg[i] <= w_reg[i+1];
         end
         w_reg[15] <= w_new;
         rnd_reg   <= rnd_reg + 6'd1;
         if (rdy) begin
            run_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/bitcoin_miner_block_design_wrapper.sv
// ---------------------------------------------------------------------------
// bitcoin_miner_block_design_wrapper
// Searches [nonce_first .. nonce_last] (32-bit wrapping) for a block header
// whose double SHA-256, in display byte order, is <= target. Header bytes
// 0..63 arrive as a midstate, so each nonce costs two compressions on one
// shared round core: 131 cycles per nonce.
//   sys_clock, sys_rst_n  clock, asynchronous active-low reset
//   start                 pulse in idle: latch inputs, begin search
//   midstate              SHA-256 state after header bytes 0..63
//   tail                  header bytes 64..75, byte 64 in [95:88]
//   nonce_first/last      inclusive nonce range
//   target                unsigned 256-bit threshold
//   busy                  search in progress
//   done                  one-cycle pulse at search end
//   found, nonce, hash    result (hit flag, nonce, display-order digest)
// ---------------------------------------------------------------------------
module bitcoin_miner_block_design_wrapper
   import miner_pkg::*;
(
   input  logic         sys_clock,
   input  logic         sys_rst_n,
   input  logic         start,
   input  logic [255:0] midstate,
   input  logic [95:0]  tail,
   input  logic [31:0]  nonce_first,
   input  logic [31:0]  nonce_last,
   input  logic [255:0] target,
   output logic         busy,
   output logic         done,
   output logic         found,
   output logic [31:0]  nonce,
   output logic [255:0] hash
);

   miner_state_t state_reg, state_next;

   logic [255:0] midstate_reg;
   logic [95:0]  tail_reg;
   logic [31:0]  nonce_last_reg;
   logic [255:0] target_reg;
   logic [31:0]  nonce_cnt_reg;

   logic         busy_reg, done_reg, found_reg;
   logic [31:0]  nonce_reg;
   logic [255:0] hash_reg;

   logic         core_load, core_rdy;
   logic [255:0] core_init, core_digest;
   logic [511:0] core_block;
   logic [511:0] msg1, msg2;
   logic [255:0] hash_calc;
   logic         hit, last_nonce, search_end;

   sha256_round_core u_core (
      .clk        (sys_clock),
      .rst_n      (sys_rst_n),
      .load       (core_load),
      .init_state (core_init),
      .block      (core_block),
      .digest     (core_digest),
      .rdy        (core_rdy)
   );

   // Second header block: tail, nonce little-endian, pad, 640-bit length.
   // Digest block: first digest, pad, 256-bit length.
   assign msg1 = {tail_reg, byte_swap32(nonce_cnt_reg), 32'h8000_0000, 288'd0, 64'd640};
   assign msg2 = {core_digest, 32'h8000_0000, 160'd0, 64'd256};

   assign hash_calc  = byte_reverse256(core_digest);
   assign hit        = (hash_calc <= target_reg);
   assign last_nonce = (nonce_cnt_reg == nonce_last_reg);
   assign search_end = hit || last_nonce;

   // The core is loaded on the single cycle that precedes each round phase;
   // in C1_FIN the digest of the first hash feeds straight into the second.
   always_comb begin
      core_load  = 1'b0;
      core_init  = SHA256_IV;
      core_block = msg2;
      if (state_reg == C1_LOAD) begin
         core_load  = 1'b1;
         core_init  = midstate_reg;
         core_block = msg1;
      end else if (state_reg == C1_FIN) begin
         core_load  = 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = C1_LOAD;
         C1_LOAD: state_next = C1_RND;
         C1_RND:  if (core_rdy) state_next = C1_FIN;
         C1_FIN:  state_next = C2_RND;
         C2_RND:  if (core_rdy) state_next = C2_FIN;
         C2_FIN:  state_next = search_end ? IDLE : C1_LOAD;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clock or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge sys_clock or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         midstate_reg   <= '0;
         tail_reg       <= '0;
         nonce_last_reg <= '0;
         target_reg     <= '0;
         nonce_cnt_reg  <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         found_reg      <= 1'b0;
         nonce_reg      <= '0;
         hash_reg       <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  midstate_reg   <= midstate;
                  tail_reg       <= tail;
                  nonce_last_reg <= nonce_last;
                  target_reg     <= target;
                  nonce_cnt_reg  <= nonce_first;
                  busy_reg       <= 1'b1;
                  found_reg      <= 1'b0;
                  nonce_reg      <= '0;
                  hash_reg       <= '0;
               end
            end
            C2_FIN: begin
               if (search_end) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  found_reg <= hit;
                  nonce_reg <= nonce_cnt_reg;
                  hash_reg  <= hash_calc;
               end else begin
                  nonce_cnt_reg <= nonce_cnt_reg + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = busy_reg;
   assign done  = done_reg;
   assign found = found_reg;
   assign nonce = nonce_reg;
   assign hash  = hash_reg;

endmodule

// File: tb/tb_bitcoin_miner_block_design_wrapper.sv
module tb_bitcoin_miner_block_design_wrapper;

   logic         sys_clock   = 1'b0;
   logic         sys_rst_n   = 1'b0;
   logic         start       = 1'b0;
   logic [255:0] midstate    = '0;
   logic [95:0]  tail        = '0;
   logic [31:0]  nonce_first = '0;
   logic [31:0]  nonce_last  = '0;
   logic [255:0] target      = '0;
   logic         busy, done, found;
   logic [31:0]  nonce;
   logic [255:0] hash;

   int tests = 0;
   int fails = 0;

   always #5 sys_clock = ~sys_clock;

   bitcoin_miner_block_design_wrapper dut (
      .sys_clock   (sys_clock),
      .sys_rst_n   (sys_rst_n),
      .start       (start),
      .midstate    (midstate),
      .tail        (tail),
      .nonce_first (nonce_first),
      .nonce_last  (nonce_last),
      .target      (target),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .nonce       (nonce),
      .hash        (hash)
   );

   // ---------------- reference model: byte-oriented SHA-256 ----------------
   localparam logic [31:0] MK [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] M_IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

   // Genesis header: version, zero prev-hash, first 28 merkle bytes; then tail.
   localparam logic [511:0] GEN_BLK1 = {32'h01000000, 256'd0,
      224'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa};
   localparam logic [95:0]  GEN_TAIL = 96'h4b1e5e4a29ab5f49ffff001d;
   localparam logic [255:0] GEN_TARGET = {32'h00000000, 32'hffff0000, 192'd0};
   localparam logic [255:0] GEN_HASH =
      256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

   function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] m_compress(input logic [255:0] st, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] hv [8];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = (m_ror(w[i-2], 17) ^ m_ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (m_ror(w[i-15], 7) ^ m_ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      for (int i = 0; i < 8; i++) hv[i] = st[255-32*i -: 32];
      a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
      for (int i = 0; i < 64; i++) begin
         t1 = h + (m_ror(e, 6) ^ m_ror(e, 11) ^ m_ror(e, 25)) + ((e & f) ^ (~e & g)) + MK[i] + w[i];
         t2 = (m_ror(a, 2) ^ m_ror(a, 13) ^ m_ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
              hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
   endfunction

   // Finish a SHA-256 over msg, given the state after 'prior' already-hashed bytes.
   function automatic logic [255:0] m_sha_finish(input logic [255:0] st, input logic [7:0] msg[$],
                                                 input int prior);
      logic [7:0]   m[$];
      logic [63:0]  bits;
      logic [511:0] blk;
      logic [255:0] s;
      m = msg;
      bits = 64'((prior + m.size()) * 8);
      m.push_back(8'h80);
      while ((m.size() % 64) != 56) m.push_back(8'h00);
      for (int i = 7; i >= 0; i--) m.push_back(bits[8*i +: 8]);
      s = st;
      for (int bk = 0; bk < m.size() / 64; bk++) begin
         for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = m[64*bk + j];
         s = m_compress(s, blk);
      end
      return s;
   endfunction

   function automatic logic [255:0] m_hash(input logic [255:0] ms, input logic [95:0] tl,
                                           input logic [31:0] n);
      logic [7:0]   q[$];
      logic [7:0]   q2[$];
      logic [255:0] d1, d2, disp;
      for (int i = 0; i < 12; i++) q.push_back(tl[95-8*i -: 8]);
      for (int i = 0; i < 4; i++)  q.push_back(n[8*i +: 8]);
      d1 = m_sha_finish(ms, q, 64);
      for (int i = 0; i < 32; i++) q2.push_back(d1[255-8*i -: 8]);
      d2 = m_sha_finish(M_IV, q2, 0);
      for (int i = 0; i < 32; i++) disp[8*i +: 8] = d2[255-8*i -: 8];
      return disp;
   endfunction

   function automatic void m_search(input logic [255:0] ms, input logic [95:0] tl,
                                    input logic [31:0] nf, input logic [31:0] nl,
                                    input logic [255:0] tg, output logic f, output logic [31:0] n,
                                    output logic [255:0] h, output int cyc);
      logic [31:0] cur;
      cur = nf; cyc = 0; f = 1'b0; n = nf; h = '0;
      for (int k = 0; k < 1000; k++) begin
         h = m_hash(ms, tl, cur);
         cyc += 131;
         n = cur;
         if (h <= tg) begin f = 1'b1; return; end
         if (cur == nl) return;
         cur = cur + 32'd1;
      end
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_search(input logic [255:0] ms, input logic [95:0] tl, input logic [31:0] nf,
                             input logic [31:0] nl, input logic [255:0] tg, input bit poke,
                             output int cyc, output bit timeout);
      @(negedge sys_clock);
      midstate = ms; tail = tl; nonce_first = nf; nonce_last = nl; target = tg;
      start = 1'b1;
      @(posedge sys_clock);
      #1 start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      cyc = 0; timeout = 1'b0;
      while (1) begin
         @(posedge sys_clock);
         cyc++;
         #1;
         if (poke && cyc == 50) begin
            // a second start while busy must not disturb the running search
            start = 1'b1; nonce_first = nf + 32'd100; target = '0;
         end else if (poke && cyc == 51) begin
            start = 1'b0;
         end
         if (done) break;
         if (cyc > 20000) begin timeout = 1'b1; break; end
      end
   endtask

   task automatic check_result(input string name, input logic ef, input logic [31:0] en,
                               input logic [255:0] eh, input int ec, input int cyc, input bit to);
      chk({name, "_timeout"}, to, 1'b0);
      chk({name, "_found"}, found, ef);
      chk({name, "_nonce"}, nonce, en);
      chk({name, "_hash"}, hash, eh);
      chk({name, "_cycles"}, cyc, ec);
      $display("[TB] %s: found=%0b nonce=%0d cycles=%0d hash=%h", name, found, nonce, cyc, hash);
      @(posedge sys_clock);
      #1;
      chk({name, "_done_pulse"}, done, 1'b0);
      chk({name, "_busy_idle"}, busy, 1'b0);
      chk({name, "_found_hold"}, found, ef);
   endtask

   typedef struct {
      string        name;
      logic [31:0]  nf;
      logic [31:0]  nl;
      logic [255:0] tgt;
      logic         exp_found;
      logic [31:0]  exp_nonce;
      int           exp_cyc;
   } vec_t;

   initial begin
      vec_t         vecs[4];
      logic [255:0] gmid, mh, rms, rtg;
      logic [95:0]  rtl_tail;
      logic [31:0]  mn, rnf, rnl;
      logic         mf;
      int           mc, cyc;
      bit           to, bad;

      vecs[0] = '{"genesis_hit", 32'd2083236890, 32'd2083236900, GEN_TARGET, 1'b1, 32'd2083236893, 524};
      vecs[1] = '{"genesis_miss", 32'd0, 32'd3, GEN_TARGET, 1'b0, 32'd3, 524};
      vecs[2] = '{"trivial_target", 32'd5, 32'd9, {256{1'b1}}, 1'b1, 32'd5, 131};
      vecs[3] = '{"wrap_range", 32'hfffffffe, 32'h00000001, 256'd0, 1'b0, 32'd1, 524};

      gmid = m_compress(M_IV, GEN_BLK1);

      // reset: outputs clear, then idle with start low
      repeat (3) @(posedge sys_clock);
      #1;
      chk("reset_outputs", {busy, done, found, nonce, hash}, '0);
      @(negedge sys_clock) sys_rst_n = 1'b1;
      bad = 1'b0;
      repeat (1000) begin
         @(posedge sys_clock);
         #1 if (busy || done) bad = 1'b1;
      end
      chk("idle_1000", bad, 1'b0);
      $display("[TB] idle: 1000 cycles busy/done stayed low=%0b", !bad);

      // table-driven directed vectors on the genesis header
      foreach (vecs[i]) begin
         run_search(gmid, GEN_TAIL, vecs[i].nf, vecs[i].nl, vecs[i].tgt, (i == 2), cyc, to);
         m_search(gmid, GEN_TAIL, vecs[i].nf, vecs[i].nl, vecs[i].tgt, mf, mn, mh, mc);
         if (i == 0) chk("genesis_hash_const", hash, GEN_HASH);
         check_result(vecs[i].name, vecs[i].exp_found, vecs[i].exp_nonce, mh,
                      vecs[i].exp_cyc, cyc, to);
      end

      // randomized headers, small ranges, targets biased so hits and misses both occur
      for (int r = 0; r < 8; r++) begin
         rms = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
         rtl_tail = {$urandom(), $urandom(), $urandom()};
         rnf = $urandom();
         if (r == 3) rnf = 32'hffffffff;
         rnl = rnf + 32'($urandom_range(0, 2));
         rtg = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
         rtg = rtg >> $urandom_range(0, 3);
         m_search(rms, rtl_tail, rnf, rnl, rtg, mf, mn, mh, mc);
         run_search(rms, rtl_tail, rnf, rnl, rtg, 1'b0, cyc, to);
         check_result($sformatf("random_%0d", r), mf, mn, mh, mc, cyc, to);
      end

      // reset in the middle of a search
      @(negedge sys_clock);
      midstate = gmid; tail = GEN_TAIL; nonce_first = 32'd0; nonce_last = 32'd3;
      target = GEN_TARGET; start = 1'b1;
      @(posedge sys_clock);
      #1 start = 1'b0;
      repeat (199) @(posedge sys_clock);
      #1 sys_rst_n = 1'b0;
      #1 chk("midreset_outputs", {busy, done, found, nonce, hash}, '0);
      $display("[TB] midreset: busy=%0b done=%0b after async reset", busy, done);
      bad = 1'b0;
      repeat (3) @(posedge sys_clock);
      @(negedge sys_clock) sys_rst_n = 1'b1;
      repeat (600) begin
         @(posedge sys_clock);
         #1 if (busy || done) bad = 1'b1;
      end
      chk("midreset_no_done", bad, 1'b0);
      run_search(gmid, GEN_TAIL, 32'd5, 32'd9, {256{1'b1}}, 1'b0, cyc, to);
      m_search(gmid, GEN_TAIL, 32'd5, 32'd9, {256{1'b1}}, mf, mn, mh, mc);
      check_result("after_reset", 1'b1, 32'd5, mh, 131, cyc, to);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
